// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and signed overflow flag.
// Optional macro KSA_SAT_EN: signed saturation of sum on overflow (latency unchanged).
module ksa_pipe_adder #(
   parameter int WIDTH     = 16,
   parameter int REG_EVERY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int LVL = $clog2(WIDTH);
   localparam int NS  = (LVL + REG_EVERY - 1) / REG_EVERY;

   // Tree vectors are shifted up one bit: bit 0 holds c0 (g=c0, p=0), bit j holds operand bit j-1,
   // so after the tree tg[j] is directly the carry into operand bit j.
   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] tg;
      logic [WIDTH-1:0] tp;
      logic [WIDTH-1:0] op;
      logic             gm;
      logic             xs;
      logic             ys;
   } slice_t;

   slice_t [NS-1:0]  sl;
   slice_t           stage0;
   slice_t           tail;
   logic             adv;
   logic [WIDTH-1:0] ye;
   logic [WIDTH-1:0] g0;
   logic             c0;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] fin_sum;
   logic             fin_cout;
   logic             fin_ovf;

   function automatic logic [WIDTH-1:0] prefix_g(input logic [WIDTH-1:0] g_in,
                                                 input logic [WIDTH-1:0] p_in,
                                                 input int first, input int last);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      g = g_in;
      p = p_in;
      for (int k = 0; k < LVL; k++) begin
         if (k >= first && k < last) begin
            // NOTE: walking j downwards lets the in-place update read the previous level's
            // values at j - 2^k before they are overwritten.
            for (int j = WIDTH - 1; j >= (1 << k); j--) begin
               g[j] = g[j] | (p[j] & g[j - (1 << k)]);
               p[j] = p[j] & p[j - (1 << k)];
            end
         end
      end
      return g;
   endfunction

   function automatic logic [WIDTH-1:0] prefix_p(input logic [WIDTH-1:0] p_in,
                                                 input int first, input int last);
      logic [WIDTH-1:0] p;
      p = p_in;
      for (int k = 0; k < LVL; k++) begin
         if (k >= first && k < last) begin
            for (int j = WIDTH - 1; j >= (1 << k); j--) begin
               p[j] = p[j] & p[j - (1 << k)];
            end
         end
      end
      return p;
   endfunction

   function automatic slice_t advance(input slice_t a, input int s);
      slice_t b;
      b    = a;
      b.tg = prefix_g(a.tg, a.tp, s * REG_EVERY, (s + 1) * REG_EVERY);
      b.tp = prefix_p(a.tp, s * REG_EVERY, (s + 1) * REG_EVERY);
      return b;
   endfunction

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   always_comb begin
      ye        = sub ? ~y : y;
      c0        = sub | cin;
      g0        = x & ye;
      stage0.v  = in_valid & in_ready;
      stage0.op = x ^ ye;
      stage0.tg = {g0[WIDTH-2:0], c0};
      stage0.tp = {stage0.op[WIDTH-2:0], 1'b0};
      stage0.gm = g0[WIDTH-1];
      stage0.xs = x[WIDTH-1];
      stage0.ys = ye[WIDTH-1];
   end

   assign tail = sl[NS-1];

   always_comb begin
      carry    = prefix_g(tail.tg, tail.tp, (NS - 1) * REG_EVERY, LVL);
      raw      = tail.op ^ carry;
      fin_cout = tail.gm | (tail.op[WIDTH-1] & carry[WIDTH-1]);
      fin_ovf  = (tail.xs == tail.ys) & (raw[WIDTH-1] != tail.xs);
`ifdef KSA_SAT_EN
      fin_sum  = fin_ovf ? {tail.xs, {(WIDTH-1){~tail.xs}}} : raw;
`else
      fin_sum  = raw;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only the valid bits and the visible outputs are reset; slice data is
         // don't-care while its valid bit is low, so it carries no reset.
         for (int s = 0; s < NS; s++) sl[s].v <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         sl[0] <= stage0;
         for (int s = 1; s < NS; s++) sl[s] <= advance(sl[s-1], s - 1);
         out_valid <= tail.v;
         sum       <= fin_sum;
         cout      <= fin_cout;
         ovf       <= fin_ovf;
      end
   end
endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Directed and swept checks of ksa_pipe_adder: vector table, back-pressure, mid-flight reset,
// and three extra parameterisations against a behavioural reference.
module tb_ksa_pipe_adder;
   localparam int W   = 16;
   localparam int LAT = 3;
   localparam int NV  = 10;
   localparam int NSW = 120;
`ifdef KSA_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] x, y, sum;

   logic [31:0]  sx, sy;
   logic         sv, scin, ssub;
   logic [4:0]   s5_sum;
   logic [7:0]   s8_sum;
   logic [31:0]  s32_sum;
   logic         s5_v, s5_c, s5_o, s5_r;
   logic         s8_v, s8_c, s8_o, s8_r;
   logic         s32_v, s32_c, s32_o, s32_r;

   int total = 0;
   int bad   = 0;

   ksa_pipe_adder #(.WIDTH(W), .REG_EVERY(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf));

   ksa_pipe_adder #(.WIDTH(5), .REG_EVERY(1)) u5 (
      .clk(clk), .rst(rst), .in_valid(sv), .in_ready(s5_r), .x(sx[4:0]), .y(sy[4:0]),
      .cin(scin), .sub(ssub), .out_valid(s5_v), .out_ready(1'b1),
      .sum(s5_sum), .cout(s5_c), .ovf(s5_o));

   ksa_pipe_adder #(.WIDTH(8), .REG_EVERY(3)) u8 (
      .clk(clk), .rst(rst), .in_valid(sv), .in_ready(s8_r), .x(sx[7:0]), .y(sy[7:0]),
      .cin(scin), .sub(ssub), .out_valid(s8_v), .out_ready(1'b1),
      .sum(s8_sum), .cout(s8_c), .ovf(s8_o));

   ksa_pipe_adder #(.WIDTH(32), .REG_EVERY(3)) u32 (
      .clk(clk), .rst(rst), .in_valid(sv), .in_ready(s32_r), .x(sx), .y(sy),
      .cin(scin), .sub(ssub), .out_valid(s32_v), .out_ready(1'b1),
      .sum(s32_sum), .cout(s32_c), .ovf(s32_o));

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        c;
      logic        o;
   } vec_t;

   vec_t        vt [NV];
   logic [31:0] hx [NSW + 8];
   logic [31:0] hy [NSW + 8];
   logic        hv [NSW + 8];
   logic        hc [NSW + 8];
   logic        hs [NSW + 8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: widened integer add, result bits {ovf, cout, sum[31:0]}.
   function automatic logic [63:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input logic s);
      logic [63:0] mask, ae, be, full, res;
      logic        xs, ys, o, co;
      mask = (64'd1 << w) - 64'd1;
      ae   = {32'd0, a} & mask;
      be   = s ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
      full = ae + be + {63'd0, (s ? 1'b1 : c)};
      res  = full & mask;
      co   = full[w];
      xs   = ae[w-1];
      ys   = be[w-1];
      o    = (xs == ys) && (res[w-1] != xs);
      if (SAT && o) res = xs ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
      return {30'd0, o, co, res[31:0]};
   endfunction

   task automatic sweep_check(input string nm, input int w, input int lat, input int c,
                              input logic v, input logic [31:0] s, input logic co, input logic o);
      logic [63:0] e;
      int          b;
      if (c >= lat) begin
         b = c - lat;
         check($sformatf("%s valid c%0d", nm, c), {63'd0, v}, {63'd0, hv[b]});
         if (hv[b]) begin
            e = ref_add(w, hx[b], hy[b], hc[b], hs[b]);
            check($sformatf("%s sum c%0d", nm, c), {32'd0, s}, {32'd0, e[31:0]});
            check($sformatf("%s cout/ovf c%0d", nm, c), {62'd0, co, o}, {62'd0, e[32], e[33]});
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
      vt[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
      vt[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vt[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
      vt[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[7] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[8] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
      vt[9] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
      sx = '0; sy = '0; sv = 1'b0; scin = 1'b0; ssub = 1'b0;

      // Reset / idle
      @(negedge clk);
      check("rst out_valid", {63'd0, out_valid}, 64'd0);
      check("rst sum", {48'd0, sum}, 64'd0);
      check("rst cout/ovf", {62'd0, cout, ovf}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle in_ready", {63'd0, in_ready}, 64'd1);
      check("idle out_valid", {63'd0, out_valid}, 64'd0);

      // Vector table streamed back to back with out_ready held high
      for (int i = 0; i < NV + LAT; i++) begin
         @(negedge clk);
         if (i >= LAT) begin
            check($sformatf("vec%0d valid", i - LAT), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d sum", i - LAT), {48'd0, sum}, {48'd0, vt[i-LAT].s});
            check($sformatf("vec%0d cout", i - LAT), {63'd0, cout}, {63'd0, vt[i-LAT].c});
            check($sformatf("vec%0d ovf", i - LAT), {63'd0, ovf}, {63'd0, vt[i-LAT].o});
         end else begin
            check($sformatf("lat idle %0d", i), {63'd0, out_valid}, 64'd0);
         end
         if (i < NV) begin
            in_valid = 1'b1; x = vt[i].x; y = vt[i].y; cin = vt[i].cin; sub = vt[i].sub;
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("table drained", {63'd0, out_valid}, 64'd0);

      // Back-pressure: six beats, four-cycle stall from first out_valid
      begin : bp
         int got, seen, stall, cyc, waited;
         got = 0; seen = 0; stall = 0; cyc = 0;
         fork
            begin : drv
               for (int i = 0; i < 6; i++) begin
                  @(negedge clk);
                  in_valid = 1'b1; x = 16'(i); y = 16'(i); cin = 1'b1; sub = 1'b0;
                  #1;
                  waited = 0;
                  while (!in_ready && waited < 20) begin
                     @(negedge clk);
                     #1;
                     waited++;
                  end
                  if (!in_ready) check("bp accept timeout", {63'd0, in_ready}, 64'd1);
               end
               @(negedge clk);
               in_valid = 1'b0;
            end
            begin : mon
               out_ready = 1'b1;
               while (got < 6 && cyc < 80) begin
                  @(negedge clk);
                  cyc++;
                  if (out_valid && seen == 0) begin
                     seen  = 1;
                     stall = 4;
                  end
                  if (stall > 0) begin
                     out_ready = 1'b0;
                     #1;
                     check($sformatf("bp hold valid s%0d", stall), {63'd0, out_valid}, 64'd1);
                     check($sformatf("bp hold sum s%0d", stall), {48'd0, sum}, 64'd1);
                     check($sformatf("bp in_ready s%0d", stall), {63'd0, in_ready}, 64'd0);
                     stall--;
                  end else begin
                     out_ready = 1'b1;
                     #1;
                     if (out_valid) begin
                        check($sformatf("bp result %0d", got), {48'd0, sum}, 64'(2 * got + 1));
                        got++;
                     end
                  end
               end
            end
         join
         check("bp result count", 64'(got), 64'd6);
         @(negedge clk);
         check("bp no duplicate", {63'd0, out_valid}, 64'd0);
      end

      // Reset mid-flight discards in-flight beats
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; x = 16'h0001; y = 16'h0002; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      x = 16'h0003; y = 16'h0004;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst in_ready", {63'd0, in_ready}, 64'd1);
      check("midrst k0 valid", {63'd0, out_valid}, 64'd0);
      in_valid = 1'b1; x = 16'h0010; y = 16'h0020; cin = 1'b0; sub = 1'b0;
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check($sformatf("midrst k%0d valid", k), {63'd0, out_valid}, {63'd0, (k == LAT)});
         if (k == LAT) check("midrst sum", {48'd0, sum}, 64'h30);
      end

      // Parameter sweep: W5/RE1 (LAT 4), W8/RE3 (LAT 2), W32/RE3 (LAT 3)
      for (int c = 0; c < NSW + 6; c++) begin
         @(negedge clk);
         sweep_check("w5", 5, 4, c, s5_v, {27'd0, s5_sum}, s5_c, s5_o);
         sweep_check("w8", 8, 2, c, s8_v, {24'd0, s8_sum}, s8_c, s8_o);
         sweep_check("w32", 32, 3, c, s32_v, s32_sum, s32_c, s32_o);
         if (c < NSW) begin
            hv[c] = ($urandom_range(0, 3) != 0);
            hx[c] = (c == 0) ? 32'hFFFF_FFFF : $urandom;
            hy[c] = (c == 0) ? 32'h0000_0001 : $urandom;
            hc[c] = 1'($urandom_range(0, 1));
            hs[c] = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         end else begin
            hv[c] = 1'b0; hx[c] = '0; hy[c] = '0; hc[c] = 1'b0; hs[c] = 1'b0;
         end
         sv = hv[c]; sx = hx[c]; sy = hy[c]; scin = hc[c]; ssub = hs[c];
      end
      check("sweep in_ready", {61'd0, s5_r, s8_r, s32_r}, 64'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ksa_pipe_adder.md
Name: ksa_pipe_adder

Overview:
Parametrised, pipelined Kogge-Stone adder/subtractor that generalises the team's fixed 8-bit combinational prefix adder.
- Generic width; add/subtract mode per operation; signed-overflow flag.
- Valid/ready handshake with configurable pipeline depth, for datapaths (accumulators, address generators) that need one result per clock at high frequency.
- Architecture: pre-processing (g/p) stage → log2 prefix tree of black/gray cells → post-processing XOR stage, with register slices inserted between prefix levels.

Parameters:
WIDTH, 16, operand/result width in bits; any value ≥2.
REG_EVERY, 2, number of prefix levels between pipeline register slices; ≥1.
(Derived, not overridable) LVL = ceil(log2(WIDTH)); LAT = 1 + ceil(LVL/REG_EVERY). Default LAT = 3.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
x  in  WIDTH  operand A.
y  in  WIDTH  operand B.
cin  in  1  carry-in; used only when sub=0.
sub  in  1  0: x+y+cin; 1: x−y (x+~y+1, cin ignored).
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts result.
sum  out  WIDTH  result.
cout  out  1  carry-out of MSB (for sub, 1 = no borrow).
ovf  out  1  signed overflow: operands' effective sign equal, result sign differs.

Behaviour:
- Reset: every stage valid bit cleared. out_valid=0, sum=0, cout=0, ovf=0 on the first edge with rst=1. in_ready=1 from the cycle after reset releases. Reset mid-operation discards all in-flight beats; no partial result ever appears.
- Pipeline flow:
  - Global enable adv = ~out_valid | out_ready; in_ready = adv (combinational, no dependency on in_valid).
  - On adv=1, every stage shifts one position. Stage-0 valid loads in_valid & in_ready.
  - On adv=0, all stages hold (data and valid).
  - Bubbles are not collapsed; latency stays fixed at LAT cycles.
- Latency: a beat accepted at edge T presents out_valid=1 with its result after edge T+LAT, provided no stall occurs. Each stall cycle adds exactly one cycle.
- Throughput: 1 beat/cycle when out_ready is held high.
- Stage 0 (registered):
  - ye = sub ? ~y : y; c0 = sub ? 1 : cin.
  - Register g = x&ye, p = x^ye, c0, plus sign bits x[MSB] and ye[MSB] for ovf.
- Prefix tree:
  - Level k (k=0..LVL−1) combines bit i with bit i−2^k. Bits with i−2^k < 0 combine with c0 via a gray cell and are final from that level on.
  - Register slice after every REG_EVERY levels, and after the last level if not already aligned.
  - The original p vector and the sign bits are carried along with the data.
- Final stage: sum[i] = p[i] ^ carry_into[i], with carry_into[0] = c0. cout = group generate across bits WIDTH−1..0 including c0. ovf = (xs==ys) & (sum[MSB]!=xs). The output register holds these until consumed.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid are stable.
- Simultaneous events: a result consumed and a new beat accepted in the same cycle is legal and loses no data. rst has priority over all handshake activity.
- Width rule: everything is modulo 2^WIDTH. WIDTH not a power of two is handled by the i−2^k < 0 rule; no padding bits are visible.

Optional Feature:
Macro KSA_SAT_EN.
- Defined: when ovf=1, sum is replaced in the final stage by signed saturation: 0 sign + all ones if operand sign was 0, else 1 sign + all zeros. ovf and cout are still reported unmodified. Latency is unchanged.
- Undefined: sum is always the wrapped modulo result and no saturation logic is instantiated.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release → out_valid=0, sum=0x0000, cout=0, ovf=0; in_ready=1.
- Add, WIDTH=16, out_ready=1: x=0xFFFF, y=0x0001, cin=0, sub=0 accepted at edge T → at T+3 sum=0x0000, cout=1, ovf=0. Then x=0x7FFF, y=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1 (0x7FFF under KSA_SAT_EN).
- Subtract: x=0x0005, y=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then x=0x8000, y=0x0001, sub=1 → sum=0x7FFF, ovf=1 (0x8000 under KSA_SAT_EN).
- Back-pressure: stream 6 beats with x=i, y=i, cin=1 (i=0..5); hold out_ready=0 for 4 cycles from the first out_valid → out_valid and sum held; in_ready=0 while stalled. Results 1,3,5,7,9,11 arrive in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst one cycle later → out_valid stays 0 for the next LAT cycles; next accepted beat x=0x0010, y=0x0020 yields sum=0x0030 only.
- Parameter sweep: WIDTH ∈ {5, 8, 32}, REG_EVERY ∈ {1, 3} with random operands, mode and cin vs. a behavioural reference model → exact match; latency equals derived LAT.
